bist_engine: RTL and testbench
==============================

# bist_engine

Parametrised single-clock BIST engine: an LFSR pattern generator drives the circuit under test, a MISR compacts the CUT response, and a controller FSM runs a fixed-length session and compares the final signature against a golden value. It replaces the two-clock-domain LFSR/MISR pair with one clock plus a programmable settle interval. It adds start/done handshaking and on-chip pass/fail, so the testbench no longer diffs signature files. It sits between the CUT wrapper and the test-access logic.

## Interface
- IN_W, 10, CUT input width = LFSR width (>=2)
- OUT_W, 5, CUT output width = MISR width (>=2)
- LFSR_POLY, 10'h240, LFSR feedback tap mask (bit i set = tap on lfsr[i])
- LFSR_SEED, 10'h001, LFSR load value; zero is replaced by 1
- MISR_POLY, 5'h14, MISR feedback tap mask
- PAT_CNT, 960, patterns per session (>=1)
- SETTLE, 0, idle cycles between pattern apply and capture
- bistclk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level; a session begins on a cycle where start=1 and state is IDLE or DONE
- golden  in  OUT_W  expected signature, sampled in CMP
- cutout  in  OUT_W  CUT response
- cutinp  out  IN_W  current pattern (the LFSR state)
- signature  out  OUT_W  MISR state
- busy  out  1  high in LOAD, APPLY, CAPT and CMP
- done  out  1  high in DONE
- pass  out  1  valid while done=1; 1 when signature==golden
- patidx  out  $clog2(PAT_CNT+1)  number of patterns captured so far

## Operation
- LFSR next state (Fibonacci): {lfsr[IN_W-2:0], ^(lfsr & LFSR_POLY)}.
- MISR next state: {misr[OUT_W-2:0], ^(misr & MISR_POLY)} ^ cutout.
- States and transitions:
  - IDLE -> LOAD when start=1.
  - LOAD (1 cycle): lfsr<=seed, misr<=0, patidx<=0, settle counter<=0, pass<=0.
  - LOAD -> APPLY if SETTLE>0; otherwise LOAD -> CAPT.
  - APPLY: hold the pattern for SETTLE cycles, then go to CAPT.
  - CAPT (1 cycle): MISR absorbs cutout, LFSR advances, patidx++.
  - After CAPT: go to CMP if patidx reaches PAT_CNT; otherwise go to APPLY (SETTLE>0) or stay in CAPT (SETTLE=0).
  - CMP (1 cycle): pass<=(misr==golden), then go to DONE.
  - DONE: hold signature, pass and patidx. start=1 goes to LOAD (restart).
- start while busy is ignored. A start held high across DONE restarts immediately (back-to-back sessions).
- LFSR wrap-around: when PAT_CNT exceeds the LFSR period, the sequence simply repeats. No detection is performed.
- Outputs (cutinp, signature, patidx, pass) are registered. No combinational path from inputs to outputs.

## Timing
- Reset values: state=IDLE, cutinp=LFSR_SEED (zero forced to 1), signature=0, patidx=0, busy=0, done=0, pass=0.
- rst low mid-session aborts immediately to the reset values. The session is not resumed.
- Start-to-done latency: 1 (LOAD) + PAT_CNT*(SETTLE+1) + 1 (CMP) cycles. done rises on the following edge.
- cutinp is stable for SETTLE+1 cycles before and including its capture edge.
- golden must be stable during the CMP cycle.

## Structure
- Shared package bist_pkg:
  - state enum (IDLE, LOAD, APPLY, CAPT, CMP, DONE)
  - lfsr_next/misr_next functions parametrised by width and polynomial
- One natural sub-module, bist_shreg: a width/polynomial-parametrised shift register with optional parallel XOR input, instanced once as the LFSR (xor input 0) and once as the MISR.
- The FSM and counters live in bist_engine.

## Test plan
- Set IN_W=4, LFSR_POLY=4'hC, seed 1, PAT_CNT=15, SETTLE=0. Pulse start. Required response:
  - cutinp sequence 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8, each nonzero value exactly once;
  - done exactly 17 cycles after start sampled.
- Tie cutout=0 with golden=0 -> pass=1, signature=0. Repeat with golden=1 -> pass=0.
- Drive cutout=cutinp[OUT_W-1:0] with defaults. The bench reference model computes golden -> pass=1. Flip one cutout bit on pattern 500 -> pass=0, signature differs from golden.
- SETTLE=3, PAT_CNT=4 -> each cutinp value is held 4 cycles; done 1+16+1 cycles after start.
- Assert rst low at pattern 100, then re-release and start -> outputs at reset values, and the second session reproduces the same signature as an uninterrupted run.
- Hold start high through DONE -> done high for 1 cycle, LOAD follows, and the second signature equals the first. A start pulse during CAPT is ignored.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and shift-register step functions for the BIST engine.
package bist_pkg;

  // Widest shift register the step functions can handle.
  localparam int unsigned MAX_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    CAPT,
    CMP,
    DONE
  } state_e;

  // All-ones mask covering the low w bits.
  function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
    if (w >= MAX_W) return '1;
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  // Fibonacci step: shift left, feedback parity of tapped bits into bit 0.
  function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] s,
                                                 input logic [MAX_W-1:0] poly,
                                                 input int unsigned w);
    logic [MAX_W-1:0] mask;
    mask = width_mask(w);
    return ((s << 1) | MAX_W'(^(s & poly & mask))) & mask;
  endfunction

  // Signature step: LFSR step with the response folded in.
  function automatic logic [MAX_W-1:0] misr_next(input logic [MAX_W-1:0] s,
                                                 input logic [MAX_W-1:0] poly,
                                                 input logic [MAX_W-1:0] din,
                                                 input int unsigned w);
    return lfsr_next(s, poly, w) ^ (din & width_mask(w));
  endfunction

endpackage

// File: rtl/bist_shreg.sv
// Polynomial shift register with parallel load and parallel XOR input (LFSR or MISR).
module bist_shreg
  import bist_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter logic [W-1:0] POLY    = '0,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic [W-1:0] xin,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Load has priority over a shift step; otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift) begin
      q_d = W'(misr_next(MAX_W'(q_q), MAX_W'(POLY), MAX_W'(xin), W));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RST_VAL;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/bist_engine.sv
// Single-clock BIST session controller: LFSR patterns out, MISR compaction in, on-chip compare.
module bist_engine
  import bist_pkg::*;
#(
  parameter int unsigned     IN_W      = 10,
  parameter int unsigned     OUT_W     = 5,
  parameter logic [IN_W-1:0] LFSR_POLY = 10'h240,
  parameter logic [IN_W-1:0] LFSR_SEED = 10'h001,
  parameter logic [OUT_W-1:0] MISR_POLY = 5'h14,
  parameter int unsigned     PAT_CNT   = 960,
  parameter int unsigned     SETTLE    = 0
) (
  input  logic                         bistclk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [OUT_W-1:0]             golden,
  input  logic [OUT_W-1:0]             cutout,
  output logic [IN_W-1:0]              cutinp,
  output logic [OUT_W-1:0]             signature,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [$clog2(PAT_CNT+1)-1:0] patidx
);

  localparam int unsigned IDX_W = $clog2(PAT_CNT + 1);
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [IN_W-1:0] SEED = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SET_W-1:0]  set_q, set_d;
  logic              pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_c;
  logic              capt_c;
  logic [OUT_W-1:0]  misr_q;

  // Session sequencing, pattern/settle counting and final compare.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    set_d   = set_q;
    pass_d  = pass_q;
    load_c  = 1'b0;
    capt_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        load_c  = 1'b1;
        idx_d   = '0;
        set_d   = '0;
        pass_d  = 1'b0;
        state_d = (SETTLE > 0) ? APPLY : CAPT;
      end
      APPLY: begin
        if (set_q == SET_W'(SETTLE - 1)) begin
          set_d   = '0;
          state_d = CAPT;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      CAPT: begin
        capt_c = 1'b1;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_d == IDX_W'(PAT_CNT)) state_d = CMP;
        else if (SETTLE > 0)          state_d = APPLY;
        else                          state_d = CAPT;
      end
      CMP: begin
        pass_d  = (misr_q == golden);
        state_d = DONE;
      end
      DONE: begin
        if (start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {LOAD, APPLY, CAPT, CMP};
    done_d = (state_d == DONE);
  end

  // Controller registers.
  always_ff @(posedge bistclk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      set_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      set_q   <= set_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  bist_shreg #(
    .W       (IN_W),
    .POLY    (LFSR_POLY),
    .RST_VAL (SEED)
  ) u_lfsr (
    .clk      (bistclk),
    .rst_n    (rst),
    .load     (load_c),
    .load_val (SEED),
    .shift    (capt_c),
    .xin      ({IN_W{1'b0}}),
    .q        (cutinp)
  );

  bist_shreg #(
    .W       (OUT_W),
    .POLY    (MISR_POLY),
    .RST_VAL ({OUT_W{1'b0}})
  ) u_misr (
    .clk      (bistclk),
    .rst_n    (rst),
    .load     (load_c),
    .load_val ({OUT_W{1'b0}}),
    .shift    (capt_c),
    .xin      (cutout),
    .q        (misr_q)
  );

  assign signature = misr_q;
  assign patidx    = idx_q;
  assign pass      = pass_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bist_engine.sv
// Self-checking bench for bist_engine: three configurations against a sequence-level model.
module tb_bist_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Small 4-bit configuration, 15 patterns, no settle.
  logic       s_start = 1'b0;
  logic [4:0] s_golden = '0, s_cutout = '0, s_signature;
  logic [3:0] s_cutinp, s_patidx;
  logic       s_busy, s_done, s_pass;

  // Default configuration.
  logic       d_start = 1'b0;
  logic [4:0] d_golden = '0, d_tie = '0, d_flip_mask = '0, d_cutout, d_signature;
  logic [9:0] d_cutinp, d_patidx;
  logic       d_busy, d_done, d_pass;
  logic       d_follow = 1'b0;
  int         d_flip_at = -1;

  // Settle configuration: 4 patterns, 3 settle cycles.
  logic       t_start = 1'b0;
  logic [4:0] t_golden = '0, t_cutout = '0, t_signature;
  logic [9:0] t_cutinp;
  logic [2:0] t_patidx;
  logic       t_busy, t_done, t_pass;

  // CUT model for the default instance: echo the pattern, optionally corrupt one capture.
  assign d_cutout = d_follow ? (d_cutinp[4:0] ^ ((int'(d_patidx) == d_flip_at) ? d_flip_mask : 5'd0))
                             : d_tie;

  bist_engine #(.IN_W(4), .OUT_W(5), .LFSR_POLY(4'hC), .LFSR_SEED(4'h1), .MISR_POLY(5'h14),
                .PAT_CNT(15), .SETTLE(0)) u_small (
    .bistclk(clk), .rst(rst), .start(s_start), .golden(s_golden), .cutout(s_cutout),
    .cutinp(s_cutinp), .signature(s_signature), .busy(s_busy), .done(s_done),
    .pass(s_pass), .patidx(s_patidx));

  bist_engine u_dflt (
    .bistclk(clk), .rst(rst), .start(d_start), .golden(d_golden), .cutout(d_cutout),
    .cutinp(d_cutinp), .signature(d_signature), .busy(d_busy), .done(d_done),
    .pass(d_pass), .patidx(d_patidx));

  bist_engine #(.PAT_CNT(4), .SETTLE(3)) u_settle (
    .bistclk(clk), .rst(rst), .start(t_start), .golden(t_golden), .cutout(t_cutout),
    .cutinp(t_cutinp), .signature(t_signature), .busy(t_busy), .done(t_done),
    .pass(t_pass), .patidx(t_patidx));

  // Reference: one generator step as integer arithmetic.
  function automatic int unsigned gen_step(input int unsigned s, input int unsigned poly,
                                           input int unsigned w);
    return ((s * 2) % (32'd1 << w)) + int'($countones(s & poly) % 2);
  endfunction

  // Reference: full default-configuration session signature.
  function automatic int unsigned dflt_sig(input bit follow, input int unsigned tie,
                                           input int flip_at, input int unsigned flip_mask);
    int unsigned lfsr = 1;
    int unsigned misr = 0;
    int unsigned cut;
    for (int i = 0; i < 960; i++) begin
      cut = follow ? (lfsr % 32) : tie;
      if (i == flip_at) cut = cut ^ flip_mask;
      misr = gen_step(misr, 32'h14, 5) ^ cut;
      lfsr = gen_step(lfsr, 32'h240, 10);
    end
    return misr;
  endfunction

  // Launch a default-instance session with a one-cycle start pulse.
  task automatic start_d();
    @(negedge clk) d_start = 1'b1;
    @(posedge clk);
    #1 d_start = 1'b0;
  endtask

  // Count edges until done is seen on the default instance; -1 on timeout.
  task automatic wait_d_done(input int budget, output int cyc);
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (d_done) return;
      if (cyc >= budget) begin
        cyc = -1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (d_cutinp !== 10'h001) begin failures++; $display("FAIL reset_cutinp got=%0h exp=1", d_cutinp); end
    checks++; if (d_signature !== 5'd0) begin failures++; $display("FAIL reset_signature got=%0h exp=0", d_signature); end
    checks++; if (d_patidx !== 10'd0) begin failures++; $display("FAIL reset_patidx got=%0d exp=0", d_patidx); end
    checks++; if ({d_busy, d_done, d_pass} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {d_busy, d_done, d_pass}); end
    checks++; if (s_cutinp !== 4'h1) begin failures++; $display("FAIL reset_small_cutinp got=%0h exp=1", s_cutinp); end
    checks++; if (t_cutinp !== 10'h001) begin failures++; $display("FAIL reset_settle_cutinp got=%0h exp=1", t_cutinp); end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sequence();
    int unsigned lit [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
    logic [15:0] seen = '0;
    int k = 0;
    int done_at = -1;
    s_golden = 5'd0;
    @(negedge clk) s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    while (done_at < 0 && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k >= 1 && k <= 15) begin
        checks++;
        if (int'(s_cutinp) != lit[k-1]) begin
          failures++; $display("FAIL seq_pattern%0d got=%0h exp=%0h", k - 1, s_cutinp, lit[k-1]);
        end
        seen[s_cutinp] = 1'b1;
      end
      if (s_done) done_at = k;
    end
    checks++; if (seen !== 16'hFFFE) begin failures++; $display("FAIL seq_coverage got=%h exp=fffe", seen); end
    checks++; if (done_at != 17) begin failures++; $display("FAIL seq_latency got=%0d exp=17", done_at); end
    checks++; if (s_pass !== 1'b1) begin failures++; $display("FAIL seq_pass got=%b exp=1", s_pass); end
    checks++; if (s_signature !== 5'd0) begin failures++; $display("FAIL seq_signature got=%0h exp=0", s_signature); end
    // Same session against a wrong golden value.
    s_golden = 5'd1;
    @(negedge clk) s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    k = 0;
    done_at = -1;
    while (done_at < 0 && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (s_done) done_at = k;
    end
    checks++; if (done_at != 17 || s_pass !== 1'b0) begin failures++; $display("FAIL seq_badgold got_lat=%0d pass=%b exp_lat=17 pass=0", done_at, s_pass); end
  endtask

  task automatic test_tie();
    int cyc;
    int unsigned c, exp_sig, bit_sel;
    d_follow = 1'b0;
    d_tie = 5'd0;
    d_golden = 5'd0;
    start_d();
    wait_d_done(2000, cyc);
    checks++; if (cyc != 962 || d_pass !== 1'b1 || d_signature !== 5'd0) begin failures++; $display("FAIL tie0_gold0 got_lat=%0d pass=%b sig=%0h exp_lat=962 pass=1 sig=0", cyc, d_pass, d_signature); end
    d_golden = 5'd1;
    start_d();
    wait_d_done(2000, cyc);
    checks++; if (d_pass !== 1'b0) begin failures++; $display("FAIL tie0_gold1 got_pass=%b exp=0", d_pass); end
    c = $urandom_range(1, 31);
    exp_sig = dflt_sig(1'b0, c, -1, 0);
    d_tie = 5'(c);
    d_golden = 5'(exp_sig);
    start_d();
    wait_d_done(2000, cyc);
    checks++; if (int'(d_signature) != exp_sig || d_pass !== 1'b1) begin failures++; $display("FAIL tie_rand sig=%0h pass=%b exp_sig=%0h pass=1", d_signature, d_pass, exp_sig); end
    bit_sel = $urandom_range(0, 4);
    d_golden = 5'(exp_sig ^ (32'd1 << bit_sel));
    start_d();
    wait_d_done(2000, cyc);
    checks++; if (d_pass !== 1'b0) begin failures++; $display("FAIL tie_rand_badgold got_pass=%b exp=0", d_pass); end
  endtask

  task automatic test_signature();
    int cyc;
    int unsigned good, bad, mask;
    good = dflt_sig(1'b1, 0, -1, 0);
    d_follow = 1'b1;
    d_flip_at = -1;
    d_golden = 5'(good);
    start_d();
    wait_d_done(2000, cyc);
    checks++; if (cyc != 962) begin failures++; $display("FAIL sig_latency got=%0d exp=962", cyc); end
    checks++; if (int'(d_signature) != good) begin failures++; $display("FAIL sig_value got=%0h exp=%0h", d_signature, good); end
    checks++; if (d_pass !== 1'b1) begin failures++; $display("FAIL sig_pass got=%b exp=1", d_pass); end
    checks++; if (d_patidx !== 10'd960) begin failures++; $display("FAIL sig_patidx got=%0d exp=960", d_patidx); end
    mask = 32'd1 << $urandom_range(0, 4);
    bad = dflt_sig(1'b1, 0, 500, mask);
    d_flip_at = 500;
    d_flip_mask = 5'(mask);
    start_d();
    wait_d_done(2000, cyc);
    checks++; if (d_pass !== 1'b0) begin failures++; $display("FAIL flip_pass got=%b exp=0", d_pass); end
    checks++; if (int'(d_signature) != bad || int'(d_signature) == good) begin failures++; $display("FAIL flip_sig got=%0h exp=%0h golden=%0h", d_signature, bad, good); end
    d_flip_at = -1;
  endtask

  task automatic test_settle();
    int unsigned seq [4];
    int unsigned v = 1;
    int k = 0;
    int done_at = -1;
    for (int i = 0; i < 4; i++) begin
      seq[i] = v;
      v = gen_step(v, 32'h240, 10);
    end
    @(negedge clk) t_start = 1'b1;
    @(posedge clk);
    #1 t_start = 1'b0;
    while (done_at < 0 && k < 60) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k >= 1 && k <= 16) begin
        checks++;
        if (int'(t_cutinp) != seq[(k-1)/4]) begin
          failures++; $display("FAIL settle_hold_cycle%0d got=%0h exp=%0h", k, t_cutinp, seq[(k-1)/4]);
        end
      end
      if (t_done) done_at = k;
    end
    checks++; if (done_at != 18) begin failures++; $display("FAIL settle_latency got=%0d exp=18", done_at); end
    checks++; if (t_pass !== 1'b1 || t_patidx !== 3'd4) begin failures++; $display("FAIL settle_result pass=%b idx=%0d exp pass=1 idx=4", t_pass, t_patidx); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    int unsigned good;
    good = dflt_sig(1'b1, 0, -1, 0);
    d_follow = 1'b1;
    d_golden = 5'(good);
    start_d();
    while (d_patidx != 10'd100 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (d_patidx !== 10'd100) begin failures++; $display("FAIL rstmid_reach got=%0d exp=100", d_patidx); end
    rst = 1'b0;
    #1;
    checks++; if (d_cutinp !== 10'h001 || d_signature !== 5'd0 || d_patidx !== 10'd0) begin failures++; $display("FAIL rstmid_regs cutinp=%0h sig=%0h idx=%0d exp 1/0/0", d_cutinp, d_signature, d_patidx); end
    checks++; if ({d_busy, d_done, d_pass} !== 3'b000) begin failures++; $display("FAIL rstmid_flags got=%b exp=000", {d_busy, d_done, d_pass}); end
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (d_busy !== 1'b0 || d_cutinp !== 10'h001) begin failures++; $display("FAIL rstmid_noresume busy=%b cutinp=%0h exp busy=0 cutinp=1", d_busy, d_cutinp); end
    start_d();
    wait_d_done(2000, cyc);
    checks++; if (cyc != 962 || int'(d_signature) != good || d_pass !== 1'b1) begin failures++; $display("FAIL rstmid_rerun lat=%0d sig=%0h pass=%b exp lat=962 sig=%0h pass=1", cyc, d_signature, d_pass, good); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int unsigned good;
    logic [4:0] first_sig;
    good = dflt_sig(1'b1, 0, -1, 0);
    d_follow = 1'b1;
    d_golden = 5'(good);
    @(negedge clk) d_start = 1'b1;
    @(posedge clk);
    wait_d_done(2000, cyc);
    first_sig = d_signature;
    checks++; if (cyc != 962 || int'(first_sig) != good || d_pass !== 1'b1) begin failures++; $display("FAIL b2b_first lat=%0d sig=%0h pass=%b exp lat=962 sig=%0h pass=1", cyc, first_sig, d_pass, good); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (d_done !== 1'b0 || d_busy !== 1'b1) begin failures++; $display("FAIL b2b_restart done=%b busy=%b exp done=0 busy=1", d_done, d_busy); end
    d_start = 1'b0;
    repeat (100) @(posedge clk);
    #1 d_start = 1'b1;
    @(posedge clk);
    #1 d_start = 1'b0;
    wait_d_done(2000, cyc);
    checks++; if (cyc < 0 || cyc + 101 != 962) begin failures++; $display("FAIL b2b_ignore_start lat=%0d exp=962", (cyc < 0) ? cyc : cyc + 101); end
    checks++; if (d_signature !== first_sig || d_pass !== 1'b1) begin failures++; $display("FAIL b2b_second sig=%0h pass=%b exp sig=%0h pass=1", d_signature, d_pass, first_sig); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_tie();
    test_signature();
    test_settle();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
